free_list: RTL and testbench

Physical-register free list for the rename stage. It hands unused physical register numbers to the register alias table for every renamed instruction that writes a destination. At commit it takes back the previous mappings (old pdst) that the alias table reported at rename time. It also keeps the committed architectural-valid bitmap and the committed allocation pointer, so a flush restores both the alias table and the free list in one cycle.

---
 rtl/free_list.sv | 115 +++++++++++
 tb/tb_free_list.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: speculative allocation for rename, frees at commit, and a
// committed pointer plus arch-valid bitmap so a flush restores in one cycle.
module free_list #(
  parameter int unsigned PHY_REG_NUM  = 64,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned COMMIT_WIDTH = 2,
  localparam int unsigned PW          = $clog2(PHY_REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_en_i,
  input  logic [DECODE_WIDTH-1:0]      alloc_req_i,
  output logic                         alloc_ready_o,
  output logic [DECODE_WIDTH*PW-1:0]   alloc_preg_o,
  input  logic [COMMIT_WIDTH-1:0]      commit_i,
  input  logic [COMMIT_WIDTH*PW-1:0]   commit_pdest_i,
  input  logic [COMMIT_WIDTH-1:0]      commit_ppdst_valid_i,
  input  logic [COMMIT_WIDTH*PW-1:0]   commit_ppdst_i,
  input  logic                         restore_i,
  output logic [PW:0]                  free_cnt_o,
  output logic [PHY_REG_NUM-1:0]       arch_valid_o
);

  localparam logic [PW:0] FullCnt = (PW+1)'(PHY_REG_NUM);
  localparam logic [PW:0] One     = (PW+1)'(1);

  logic [PW-1:0]          r_list [PHY_REG_NUM];
  logic [PW:0]            r_head;
  logic [PW:0]            r_arch_head;
  logic [PW:0]            r_tail;
  logic [PHY_REG_NUM-1:0] r_arch_valid;

  logic [PW:0]             w_free_cnt;
  logic [PW:0]             w_req_cnt;
  logic [PW:0]             w_commit_cnt;
  logic [PW:0]             w_push_cnt;
  logic [PW:0]             w_arch_head_nxt;
  logic                    w_fire;
  logic [COMMIT_WIDTH-1:0] w_push_en;
  logic [PW-1:0]           w_push_idx [COMMIT_WIDTH];

  assign w_free_cnt = r_tail - r_head;
  assign free_cnt_o = w_free_cnt;

  // Requesting slots take consecutive list entries starting at head.
  always_comb begin
    w_req_cnt    = '0;
    alloc_preg_o = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (alloc_req_i[i]) begin
        alloc_preg_o[i*PW +: PW] = r_list[r_head[PW-1:0] + w_req_cnt[PW-1:0]];
        w_req_cnt = w_req_cnt + One;
      end
    end
  end

  assign alloc_ready_o = !restore_i && (w_free_cnt >= w_req_cnt);
  assign w_fire        = alloc_en_i && alloc_ready_o;

  // Slots are applied in order so a later clear overrides an earlier set.
  always_comb begin
    w_commit_cnt = '0;
    w_push_cnt   = '0;
    w_push_en    = '0;
    arch_valid_o = r_arch_valid;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_push_idx[i] = r_tail[PW-1:0] + w_push_cnt[PW-1:0];
      if (commit_i[i]) begin
        w_commit_cnt = w_commit_cnt + One;
        arch_valid_o[commit_pdest_i[i*PW +: PW]] = 1'b1;
        if (commit_ppdst_valid_i[i]) begin
          arch_valid_o[commit_ppdst_i[i*PW +: PW]] = 1'b0;
          w_push_en[i] = 1'b1;
          w_push_cnt   = w_push_cnt + One;
        end
      end
    end
  end

  assign w_arch_head_nxt = r_arch_head + w_commit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REG_NUM; k++) begin
        r_list[k] <= PW'(k);
      end
      r_head       <= '0;
      r_arch_head  <= '0;
      r_tail       <= FullCnt;
      r_arch_valid <= '0;
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (w_push_en[i]) begin
          r_list[w_push_idx[i]] <= commit_ppdst_i[i*PW +: PW];
        end
      end
      r_tail       <= r_tail + w_push_cnt;
      r_arch_head  <= w_arch_head_nxt;
      r_arch_valid <= arch_valid_o;
      if (restore_i) begin
        r_head <= w_arch_head_nxt;
      end else if (w_fire) begin
        r_head <= r_head + w_req_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_no_overflow: assert (w_free_cnt <= FullCnt);
      a_alloc_ready: assert (!(alloc_en_i && !restore_i && !alloc_ready_o));
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus a constrained random phase, checked through
// a scoreboard fed by a behavioural model of the list, pointers and arch bitmap.
module tb_free_list;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_en = 1'b0;
  logic [1:0]  alloc_req = '0;
  logic        alloc_ready;
  logic [11:0] alloc_preg;
  logic [1:0]  commit = '0;
  logic [11:0] commit_pdest = '0;
  logic [1:0]  commit_ppdst_valid = '0;
  logic [11:0] commit_ppdst = '0;
  logic        restore = 1'b0;
  logic [6:0]  free_cnt;
  logic [63:0] arch_valid;

  free_list #(
    .PHY_REG_NUM (64),
    .DECODE_WIDTH(2),
    .COMMIT_WIDTH(2)
  ) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alloc_en_i          (alloc_en),
    .alloc_req_i         (alloc_req),
    .alloc_ready_o       (alloc_ready),
    .alloc_preg_o        (alloc_preg),
    .commit_i            (commit),
    .commit_pdest_i      (commit_pdest),
    .commit_ppdst_valid_i(commit_ppdst_valid),
    .commit_ppdst_i      (commit_ppdst),
    .restore_i           (restore),
    .free_cnt_o          (free_cnt),
    .arch_valid_o        (arch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [5:0]  g0;
    logic [5:0]  g1;
    logic [6:0]  fc;
    logic [63:0] av;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0]  m_list [64];
  logic [6:0]  m_head, m_tail, m_arch_head;
  logic [63:0] m_av;

  logic        s_ready;
  logic [5:0]  s_g0, s_g1;
  logic [6:0]  s_fc;
  logic [63:0] s_av;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pc2(input logic [1:0] v);
    return 7'(v[0]) + 7'(v[1]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) m_list[k] = 6'(k);
    m_head      = '0;
    m_arch_head = '0;
    m_tail      = 7'd64;
    m_av        = '0;
  endtask

  // Drives one cycle of stimulus (entered just after a rising edge), scores the combinational
  // outputs at the falling edge and advances the model at the next rising edge.
  task automatic drive(input logic en, input logic [1:0] rq, input logic [1:0] cm,
                       input logic [5:0] pd0, input logic [5:0] pd1, input logic [1:0] vv,
                       input logic [5:0] pp0, input logic [5:0] pp1, input logic rs);
    exp_t       e;
    logic [5:0] pda [2];
    logic [5:0] ppa [2];
    logic [5:0] gi;
    logic [6:0] rc, off, ahn;
    logic       fire;
    pda[0] = pd0; pda[1] = pd1;
    ppa[0] = pp0; ppa[1] = pp1;
    alloc_en           = en;
    alloc_req          = rq;
    commit             = cm;
    commit_pdest       = {pd1, pd0};
    commit_ppdst_valid = vv;
    commit_ppdst       = {pp1, pp0};
    restore            = rs;
    rc      = pc2(rq);
    e.fc    = m_tail - m_head;
    e.ready = !rs && (e.fc >= rc);
    gi      = m_head[5:0] + {5'b0, rq[0]};
    e.g0    = rq[0] ? m_list[m_head[5:0]] : 6'd0;
    e.g1    = rq[1] ? m_list[gi] : 6'd0;
    e.av    = m_av;
    for (int i = 0; i < 2; i++) begin
      if (cm[i]) begin
        e.av[pda[i]] = 1'b1;
        if (vv[i]) e.av[ppa[i]] = 1'b0;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    s_ready = alloc_ready;
    s_g0    = alloc_preg[5:0];
    s_g1    = alloc_preg[11:6];
    s_fc    = free_cnt;
    s_av    = arch_valid;
    check_eq("ready", 64'(s_ready), 64'(e.ready));
    check_eq("grant0", 64'(s_g0), 64'(e.g0));
    check_eq("grant1", 64'(s_g1), 64'(e.g1));
    check_eq("free_cnt", 64'(s_fc), 64'(e.fc));
    check_eq("arch_valid", s_av, e.av);
    @(posedge clk);
    fire = en && e.ready;
    ahn  = m_arch_head + pc2(cm);
    off  = '0;
    for (int i = 0; i < 2; i++) begin
      if (cm[i] && vv[i]) begin
        m_list[m_tail[5:0] + off[5:0]] = ppa[i];
        off = off + 7'd1;
      end
    end
    m_tail      = m_tail + off;
    m_av        = e.av;
    m_arch_head = ahn;
    if (rs) m_head = ahn;
    else if (fire) m_head = m_head + rc;
    #1;
  endtask

  task automatic idle(input logic en, input logic [1:0] rq);
    drive(en, rq, 2'b00, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic do_reset(input logic en, input logic [1:0] rq);
    rst_n     = 1'b0;
    alloc_en  = en;
    alloc_req = rq;
    commit    = '0;
    commit_ppdst_valid = '0;
    restore   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [1:0] rq, cm, vv;
    logic       en, rs, rdy;
    logic [6:0] n, ahn, k;

    model_reset();
    @(posedge clk);
    do_reset(1'b0, 2'b00);

    // Reset state and basic allocation
    idle(1'b0, 2'b00);
    check_eq("rst_free_cnt", 64'(s_fc), 64'd64);
    check_eq("rst_ready", 64'(s_ready), 64'd1);
    check_eq("rst_arch_valid", s_av, 64'd0);
    idle(1'b1, 2'b11);
    check_eq("basic_g0", 64'(s_g0), 64'd0);
    check_eq("basic_g1", 64'(s_g1), 64'd1);
    idle(1'b0, 2'b11);
    check_eq("basic_cnt62", 64'(s_fc), 64'd62);
    check_eq("basic_g0b", 64'(s_g0), 64'd2);
    check_eq("basic_g1b", 64'(s_g1), 64'd3);
    // Sparse request and hold on alloc_en=0
    idle(1'b1, 2'b10);
    check_eq("sparse_g1", 64'(s_g1), 64'd2);
    check_eq("sparse_g0", 64'(s_g0), 64'd0);
    idle(1'b0, 2'b01);
    check_eq("sparse_cnt61", 64'(s_fc), 64'd61);
    check_eq("sparse_g0_next", 64'(s_g0), 64'd3);
    idle(1'b0, 2'b01);
    check_eq("hold_g0", 64'(s_g0), 64'd3);

    // Exhaustion
    for (int i = 0; i < 30; i++) idle(1'b1, 2'b11);
    idle(1'b1, 2'b01);
    idle(1'b0, 2'b01);
    check_eq("empty_cnt", 64'(s_fc), 64'd0);
    check_eq("empty_ready", 64'(s_ready), 64'd0);
    idle(1'b0, 2'b00);
    check_eq("empty_req0_ready", 64'(s_ready), 64'd1);

    // Commit/free with no same-cycle bypass, then wrap
    drive(1'b0, 2'b01, 2'b01, 6'd1, 6'd0, 2'b01, 6'd0, 6'd0, 1'b0);
    check_eq("commit_av", 64'(s_av[1:0]), 64'b10);
    check_eq("no_bypass_ready", 64'(s_ready), 64'd0);
    drive(1'b1, 2'b01, 2'b01, 6'd2, 6'd0, 2'b01, 6'd7, 6'd0, 1'b0);
    check_eq("freed_ready", 64'(s_ready), 64'd1);
    check_eq("freed_g0", 64'(s_g0), 64'd0);
    check_eq("commit2_av", 64'(s_av[2:0]), 64'b110);
    idle(1'b0, 2'b01);
    check_eq("wrap_cnt", 64'(s_fc), 64'd1);
    check_eq("wrap_g0", 64'(s_g0), 64'd7);
    drive(1'b0, 2'b00, 2'b11, 6'd10, 6'd11, 2'b10, 6'd0, 6'd10, 1'b0);
    check_eq("order_av", 64'(s_av[11:10]), 64'b10);

    // Restore with a simultaneous commit
    do_reset(1'b0, 2'b00);
    idle(1'b1, 2'b11);
    idle(1'b1, 2'b11);
    drive(1'b0, 2'b00, 2'b01, 6'd0, 6'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    drive(1'b1, 2'b01, 2'b01, 6'd1, 6'd0, 2'b00, 6'd0, 6'd0, 1'b1);
    check_eq("restore_ready", 64'(s_ready), 64'd0);
    check_eq("restore_av", 64'(s_av[1:0]), 64'b11);
    idle(1'b0, 2'b11);
    check_eq("restore_g0", 64'(s_g0), 64'd2);
    check_eq("restore_g1", 64'(s_g1), 64'd3);
    check_eq("restore_cnt", 64'(s_fc), 64'd62);

    // Reset during traffic
    idle(1'b1, 2'b11);
    do_reset(1'b1, 2'b11);
    idle(1'b0, 2'b11);
    check_eq("midrst_cnt", 64'(s_fc), 64'd64);
    check_eq("midrst_av", s_av, 64'd0);
    check_eq("midrst_g0", 64'(s_g0), 64'd0);
    check_eq("midrst_g1", 64'(s_g1), 64'd1);

    // Random traffic, constrained to legal commit/free behaviour
    for (int t = 0; t < 400; t++) begin
      rq  = 2'($urandom);
      rs  = ($urandom_range(0, 19) == 0);
      rdy = !rs && ((m_tail - m_head) >= pc2(rq));
      en  = (rdy || rs) ? 1'($urandom) : 1'b0;
      cm  = '0;
      n   = '0;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 1) == 1 && (m_head - m_arch_head) > n) begin
          cm[i] = 1'b1;
          n = n + 7'd1;
        end
      end
      ahn = m_arch_head + n;
      vv  = '0;
      k   = '0;
      for (int i = 0; i < 2; i++) begin
        if (cm[i] && $urandom_range(0, 3) != 0 && (m_tail + k + 7'd1 - ahn) <= 7'd64) begin
          vv[i] = 1'b1;
          k = k + 7'd1;
        end
      end
      drive(en, rq, cm, 6'($urandom), 6'($urandom), vv, 6'($urandom), 6'($urandom), rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
